// File: rtl/hazard_pkg.sv
// Shared encodings and defaults for the hazard control unit and its counters.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    MULDIV = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [1:0] REGWRITE_NONE = 2'b00;

  localparam int MULDIV_CYCLES_DEF = 4;

  // True when an instruction writing wr_addr feeds a consumer that reads rd_addr.
  function automatic logic reg_dep(input logic [3:0] wr_addr, input logic [3:0] rd_addr,
                                   input logic rd_used);
    return rd_used && (wr_addr == rd_addr);
  endfunction

endpackage

// File: rtl/stall_counter.sv
// Loadable counter: counts down and stops at zero, or counts up and saturates (SAT_UP=1).
// Latency: one cycle from load/en to cnt; at_end is combinational from cnt.
// Backpressure: none; en is ignored once the count has reached its end value.
module stall_counter #(
  parameter int W      = 4,
  parameter bit SAT_UP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         at_end
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_cnt;
  logic         w_at_end;

  assign w_at_end = SAT_UP ? (r_cnt == '1) : (r_cnt == '0);

  // Count register: reset clears, load wins over enable, counting stops at the end value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (en && !w_at_end) begin
      r_cnt <= SAT_UP ? (r_cnt + ONE) : (r_cnt - ONE);
    end
  end

  assign cnt    = r_cnt;
  assign at_end = w_at_end;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: front-end stalls, ID/EX bubbles, EX hold for mul/div, IF/ID flush.
// Latency: outputs are combinational from state and current inputs (zero-cycle stall).
// Backpressure: drops pc_write/ifid_write to freeze the front end; define HAZARD_STATS_EN for stats.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W    = 4,
  parameter int MULDIV_CYCLES = MULDIV_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_op1,
  input  logic [REG_ADDR_W-1:0] id_op2,
  input  logic                  id_use_op1,
  input  logic                  id_use_op2,
  input  logic                  id_is_branch,
  input  logic                  branch_taken,
  input  logic [REG_ADDR_W-1:0] ex_op1,
  input  logic [1:0]            ex_regwrite,
  input  logic                  ex_mem_read,
  input  logic                  ex_muldiv,
  input  logic                  halt,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic                  idex_hold,
  output logic                  exmem_bubble,
  output logic                  muldiv_busy,
  output logic                  halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           flush_count
`endif
);

  // Entry cycle already stalls, so the counter covers the remaining MULDIV_CYCLES-1 cycles.
  localparam logic [3:0] MDV_LOAD = 4'(MULDIV_CYCLES - 2);

  state_t     r_state;
  state_t     w_next_state;
  logic       w_ex_writes;
  logic       w_load_use;
  logic       w_branch_data;
  logic       w_data_stall;
  logic       w_mdv_start;
  logic       w_mdv_en;
  logic [3:0] w_mdv_cnt;
  logic       w_mdv_zero;

  assign w_ex_writes   = (ex_regwrite != REGWRITE_NONE);
  assign w_load_use    = ex_mem_read && w_ex_writes &&
                         (reg_dep(ex_op1, id_op1, id_use_op1) || reg_dep(ex_op1, id_op2, id_use_op2));
  assign w_branch_data = id_is_branch && w_ex_writes && (ex_op1 == id_op1);
  assign w_data_stall  = w_load_use || w_branch_data;

  assign w_mdv_start = (r_state == RUN) && ex_muldiv && !halt;
  assign w_mdv_en    = (r_state == MULDIV) && (w_mdv_cnt != 4'd0);

  stall_counter #(.W(4), .SAT_UP(1'b0)) u_mdv_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (w_mdv_start),
    .load_val (MDV_LOAD),
    .en       (w_mdv_en),
    .cnt      (w_mdv_cnt),
    .at_end   (w_mdv_zero)
  );

  // State register: reset returns to RUN from any state, including mid mul/div or halted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: halt dominates, mul/div runs until the countdown reaches zero, HALTED is sticky.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RUN: begin
        if (halt) begin
          w_next_state = HALTED;
        end else if (ex_muldiv) begin
          w_next_state = MULDIV;
        end
      end
      MULDIV: begin
        if (halt) begin
          w_next_state = HALTED;
        end else if (w_mdv_zero) begin
          w_next_state = RUN;
        end
      end
      HALTED:  w_next_state = HALTED;
      default: w_next_state = RUN;
    endcase
  end

  // Outputs: priority is reset, halt, mul/div, data stall, then taken-branch flush.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    idex_hold    = 1'b0;
    exmem_bubble = 1'b0;
    muldiv_busy  = 1'b0;
    halted       = 1'b0;
    if (rst) begin
      pc_write = 1'b1;
    end else if (halt || (r_state == HALTED)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      halted      = 1'b1;
    end else if ((r_state == MULDIV) || ex_muldiv) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_hold    = 1'b1;
      exmem_bubble = 1'b1;
      muldiv_busy  = 1'b1;
    end else if (w_data_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  logic w_stall_sat;
  logic w_flush_sat;
  logic w_stall_inc;
  logic w_flush_inc;

  // Halted cycles are not stalls; counting stops at all-ones.
  assign w_stall_inc = !pc_write && (r_state != HALTED) && !w_stall_sat;
  assign w_flush_inc = ifid_flush && !w_flush_sat;

  stall_counter #(.W(16), .SAT_UP(1'b1)) u_stall_stats (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (16'h0000),
    .en       (w_stall_inc),
    .cnt      (stall_cycles),
    .at_end   (w_stall_sat)
  );

  stall_counter #(.W(16), .SAT_UP(1'b1)) u_flush_stats (
    .clk      (clk),
    .rst      (rst),
    .load     (1'b0),
    .load_val (16'h0000),
    .en       (w_flush_inc),
    .cnt      (flush_count),
    .at_end   (w_flush_sat)
  );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (mul/div occupancy 4 and 2) share one stimulus.
// Each cycle both are compared against a cycle-level reference model of the hazard rules.
// Directed scenarios first, then randomized traffic; HAZARD_STATS_EN adds counter checks.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_op1, id_op2, ex_op1;
  logic       id_use_op1, id_use_op2, id_is_branch, branch_taken;
  logic [1:0] ex_regwrite;
  logic       ex_mem_read, ex_muldiv, halt;

  logic [1:0] pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] idex_hold, exmem_bubble, muldiv_busy, halted;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles [2];
  logic [15:0] flush_count [2];
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state per instance
  int mc [2] = '{4, 2};
  int mul_left [2];
  bit hlt [2];
  int st_cnt [2];
  int fl_cnt [2];
  int busy_tally [2];

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_ADDR_W(4), .MULDIV_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2),
    .id_use_op1(id_use_op1), .id_use_op2(id_use_op2), .id_is_branch(id_is_branch),
    .branch_taken(branch_taken), .ex_op1(ex_op1), .ex_regwrite(ex_regwrite),
    .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv), .halt(halt),
    .pc_write(pc_write[0]), .ifid_write(ifid_write[0]), .ifid_flush(ifid_flush[0]),
    .idex_bubble(idex_bubble[0]), .idex_hold(idex_hold[0]), .exmem_bubble(exmem_bubble[0]),
    .muldiv_busy(muldiv_busy[0]), .halted(halted[0])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles[0]), .flush_count(flush_count[0])
`endif
  );

  hazard_control_unit #(.REG_ADDR_W(4), .MULDIV_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst), .id_op1(id_op1), .id_op2(id_op2),
    .id_use_op1(id_use_op1), .id_use_op2(id_use_op2), .id_is_branch(id_is_branch),
    .branch_taken(branch_taken), .ex_op1(ex_op1), .ex_regwrite(ex_regwrite),
    .ex_mem_read(ex_mem_read), .ex_muldiv(ex_muldiv), .halt(halt),
    .pc_write(pc_write[1]), .ifid_write(ifid_write[1]), .ifid_flush(ifid_flush[1]),
    .idex_bubble(idex_bubble[1]), .idex_hold(idex_hold[1]), .exmem_bubble(exmem_bubble[1]),
    .muldiv_busy(muldiv_busy[1]), .halted(halted[1])
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles[1]), .flush_count(flush_count[1])
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; halt = 1'b0; ex_muldiv = 1'b0; ex_mem_read = 1'b0; ex_regwrite = 2'b00;
    ex_op1 = 4'd0; id_op1 = 4'd0; id_op2 = 4'd0; id_use_op1 = 1'b0; id_use_op2 = 1'b0;
    id_is_branch = 1'b0; branch_taken = 1'b0;
  endtask

  // One pipeline cycle: settle, compare both instances with the model, advance the model.
  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) begin
      bit pw, iw, fl, bb, hd, eb, mb, ht, lu, bd, was_halted;
      logic [7:0] exp_v, obs_v;
      pw = 1; iw = 1; fl = 0; bb = 0; hd = 0; eb = 0; mb = 0; ht = 0;
      was_halted = hlt[d];
      if (rst) begin
        mul_left[d] = 0;
        hlt[d] = 0;
      end else if (hlt[d] || halt) begin
        pw = 0; iw = 0; bb = 1; ht = 1;
        hlt[d] = 1;
      end else if (mul_left[d] > 0 || ex_muldiv) begin
        pw = 0; iw = 0; hd = 1; eb = 1; mb = 1;
        mul_left[d] = (mul_left[d] > 0) ? mul_left[d] - 1 : mc[d] - 1;
      end else begin
        lu = ex_mem_read && (ex_regwrite != 0) &&
             ((id_use_op1 && ex_op1 == id_op1) || (id_use_op2 && ex_op1 == id_op2));
        bd = id_is_branch && (ex_regwrite != 0) && (ex_op1 == id_op1);
        if (lu || bd) begin
          pw = 0; iw = 0; bb = 1;
        end else if (branch_taken) begin
          fl = 1;
        end
      end
      exp_v = {pw, iw, fl, bb, hd, eb, mb, ht};
      obs_v = {pc_write[d], ifid_write[d], ifid_flush[d], idex_bubble[d],
               idex_hold[d], exmem_bubble[d], muldiv_busy[d], halted[d]};
      check($sformatf("outs_dut%0d", d), {8'h00, obs_v}, {8'h00, exp_v});
      busy_tally[d] += (muldiv_busy[d] === 1'b1) ? 1 : 0;
`ifdef HAZARD_STATS_EN
      check($sformatf("stall_cycles_dut%0d", d), stall_cycles[d], 16'(st_cnt[d]));
      check($sformatf("flush_count_dut%0d", d), flush_count[d], 16'(fl_cnt[d]));
`endif
      if (rst) begin
        st_cnt[d] = 0;
        fl_cnt[d] = 0;
      end else begin
        if (!pw && !was_halted && st_cnt[d] < 65535) st_cnt[d]++;
        if (fl && fl_cnt[d] < 65535) fl_cnt[d]++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    // Reset state: RUN outputs while rst is held
    step();
    idle();
    step();

    // Load-use: one bubble cycle, then normal flow
    ex_mem_read = 1'b1; ex_regwrite = 2'b11; ex_op1 = 4'd3; id_op2 = 4'd3; id_use_op2 = 1'b1;
    step();
    idle();
    step();

    // Branch-data with taken branch: stall without flush, then flush once the producer has left EX
    id_is_branch = 1'b1; ex_regwrite = 2'b01; ex_op1 = 4'd5; id_op1 = 4'd5; branch_taken = 1'b1;
    step();
    ex_regwrite = 2'b00;
    step();
    idle();
    step();

    // Mul/div occupancy: EX presents the op once; count busy cycles per instance
    busy_tally[0] = 0; busy_tally[1] = 0;
    ex_muldiv = 1'b1;
    step();
    ex_muldiv = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("muldiv_busy_cycles_4", 16'(busy_tally[0]), 16'd4);
    check("muldiv_busy_cycles_2", 16'(busy_tally[1]), 16'd2);

    // Reset in the 2nd busy cycle
    ex_muldiv = 1'b1;
    step();
    ex_muldiv = 1'b0; rst = 1'b1;
    step();
    idle();
    #1;
    check("rst_mdv_pc_write", {15'd0, pc_write[0]}, 16'd1);
    check("rst_mdv_busy", {15'd0, muldiv_busy[0]}, 16'd0);
    step();

    // Halt together with load-use and taken branch: halt wins and sticks until reset
    halt = 1'b1; branch_taken = 1'b1;
    ex_mem_read = 1'b1; ex_regwrite = 2'b10; ex_op1 = 4'd7; id_op1 = 4'd7; id_use_op1 = 1'b1;
    step();
    idle();
    branch_taken = 1'b1; ex_muldiv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("halt_sticky", {15'd0, halted[0]}, 16'd1);
      step();
    end
    rst = 1'b1;
    step();
    idle();
    step();

    // Randomized traffic over a small register range to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 39) == 0);
      halt         = ($urandom_range(0, 59) == 0);
      ex_muldiv    = ($urandom_range(0, 9) == 0);
      ex_mem_read  = 1'($urandom_range(0, 1));
      ex_regwrite  = 2'($urandom_range(0, 3));
      ex_op1       = 4'($urandom_range(0, 3));
      id_op1       = 4'($urandom_range(0, 3));
      id_op2       = 4'($urandom_range(0, 3));
      id_use_op1   = 1'($urandom_range(0, 1));
      id_use_op2   = 1'($urandom_range(0, 1));
      id_is_branch = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      step();
    end

`ifdef HAZARD_STATS_EN
    // Saturation: hold a load-use hazard long enough to pin stall_cycles at all-ones
    idle();
    rst = 1'b1;
    step();
    idle();
    ex_mem_read = 1'b1; ex_regwrite = 2'b11; ex_op1 = 4'd3; id_op2 = 4'd3; id_use_op2 = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    #1;
    check("stall_sat", stall_cycles[0], 16'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Companion to the forwarding unit in the 4-stage-plus-WB pipeline (IF/ID/EX/MEM/WB), covering the other side of operand delivery.
- Forwarding supplies operands that already exist. This block handles operands that cannot be forwarded yet: it stalls the front end, injects bubbles, holds EX during multi-cycle mul/div, and flushes IF/ID on taken branches.
- Sits beside the forwarding unit and drives the pipeline-register write enables and the PC write enable.

Parameters:
- REG_ADDR_W, 4, register address width (16 GPRs).
- MULDIV_CYCLES, 4, total EX occupancy of a mul/div op in cycles; range 2..15.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_op1  in  REG_ADDR_W  source reg 1 of instruction in ID
- id_op2  in  REG_ADDR_W  source reg 2 of instruction in ID
- id_use_op1  in  1  ID instruction reads id_op1
- id_use_op2  in  1  ID instruction reads id_op2
- id_is_branch  in  1  ID holds a branch (compares id_op1 in ID)
- branch_taken  in  1  branch resolved taken in ID this cycle
- ex_op1  in  REG_ADDR_W  destination reg of instruction in EX
- ex_regwrite  in  2  EX write code; 2'b00 = no write, any other value = writes ex_op1
- ex_mem_read  in  1  EX instruction is a load
- ex_muldiv  in  1  EX instruction is mul/div
- halt  in  1  halt instruction reached EX
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_bubble  out  1  load NOP into ID/EX
- idex_hold  out  1  hold ID/EX contents
- exmem_bubble  out  1  load NOP into EX/MEM
- muldiv_busy  out  1  mul/div in progress
- halted  out  1  core halted

Behaviour:
- State machine with states RUN, MULDIV, HALTED, held in a 2-bit state register, plus a 4-bit countdown counter cnt. Both update on posedge clk.
- rst (sync): state=RUN, cnt=0. With rst asserted, all outputs equal RUN-with-no-hazard values: pc_write=1, ifid_write=1, all others 0. rst overrides any state, including mid-MULDIV or HALTED.
- Outputs are combinational from state and current inputs. Zero-cycle latency is required so a stall takes effect in the same cycle the hazard is visible.
- Priority, highest first: rst > halt/HALTED > MULDIV > data stall > branch flush.
- HALTED state: pc_write=0, ifid_write=0, idex_bubble=1, halted=1. Only rst exits. halt seen in RUN drives the HALTED outputs the same cycle and sets state=HALTED.
- RUN to MULDIV: when ex_muldiv=1, set cnt=MULDIV_CYCLES-2 and state=MULDIV. The entry cycle itself already stalls.
- Stall outputs in the entry cycle and in every MULDIV cycle: pc_write=0, ifid_write=0, idex_hold=1, exmem_bubble=1, muldiv_busy=1.
- MULDIV: decrement cnt each cycle. In the cycle with cnt==0, state returns to RUN and muldiv_busy is still 1. Total stall equals MULDIV_CYCLES cycles. On the following RUN cycle, ex_muldiv for the same instruction has left EX.
- Data stall, evaluated only in RUN with no mul/div or halt:
  - load-use: ex_mem_read and ex_regwrite!=0 and ((id_use_op1 and ex_op1==id_op1) or (id_use_op2 and ex_op1==id_op2)).
  - branch-data: id_is_branch and ex_regwrite!=0 and ex_op1==id_op1.
  - Either condition gives pc_write=0, ifid_write=0, idex_bubble=1 for one cycle. The condition naturally clears the next cycle.
- Branch flush: branch_taken and no stall of any kind gives ifid_flush=1. pc_write and ifid_write stay 1. During any stall ifid_flush=0, because the branch is re-evaluated after the stall.
- Mutual exclusion: idex_bubble and idex_hold are never both 1.

Optional Feature:
- Macro HAZARD_STATS_EN.
- When defined, adds outputs stall_cycles (16-bit) and flush_count (16-bit). Both are saturating counters and are cleared by rst.
  - stall_cycles increments on every cycle with pc_write=0 and state!=HALTED.
  - flush_count increments on every cycle with ifid_flush=1.
- When undefined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Decomposition:
- Shared header hazard_pkg:
  - state encodings RUN=2'b00, MULDIV=2'b01, HALTED=2'b10
  - REGWRITE_NONE=2'b00
  - default MULDIV_CYCLES
- One natural sub-module, stall_counter: loadable down-counter with a zero flag, used for the MULDIV countdown. The stats counters reuse a saturating-up variant of it when HAZARD_STATS_EN is defined.

Test Plan:
- Load-use: ex_mem_read=1, ex_regwrite=2'b11, ex_op1=4'd3, id_op2=4'd3, id_use_op2=1 -> exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal flow.
- Branch-data: id_is_branch=1, ex_regwrite=2'b01, ex_op1=id_op1=4'd5, branch_taken=1 -> stall for one cycle with ifid_flush=0; the next cycle ifid_flush=1.
- Mul/div: ex_muldiv=1 with MULDIV_CYCLES=4 -> muldiv_busy, idex_hold and exmem_bubble all 1 for exactly 4 cycles, then released; check again with MULDIV_CYCLES=2.
- Reset during MULDIV: assert rst in the 2nd busy cycle -> the next cycle shows RUN outputs (pc_write=1, muldiv_busy=0).
- Halt and priority: halt=1 together with a load-use hazard and branch_taken -> halted=1, pc_write=0, ifid_flush=0, held until rst.
- Stats (HAZARD_STATS_EN): run the sequences above -> stall_cycles and flush_count match the counted cycles; force 65535 stall cycles -> counter stays at 16'hFFFF.
